// File: rtl/sync_timing_gen.sv
// sync_timing_gen: one axis of a VGA-style timing generator.
//
// Walks a counter through four segments, SYNC -> BACK -> ACTIVE -> FRONT, with
// each segment length supplied at runtime. The counter moves on a "tick", which
// is either the rising edge of `advance` (horizontal use, advance = pixel clock)
// or the level of `advance` (vertical use, advance = H instance's period_end).
//
// Parameters
//   CW              counter/length/position width
//   SYNC_ACTIVE_LOW 1: sync is low while asserted, 0: high while asserted
//   EDGE_DETECT     1: tick on rising edge of advance, 0: tick whenever advance=1
//
// Optional feature (macro SYNC_GEN_SHADOW_EN)
//   Defined: segment lengths are captured into shadow registers during reset and
//   on each period_end, so length changes only take effect at a period boundary.
//   Undefined: length inputs are used live every clock.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high
//   advance     in   pixel clock (H) or line strobe (V)
//   sync_len    in   SYNC segment length in ticks   (0 treated as 1)
//   back_len    in   BACK porch length in ticks     (0 treated as 1)
//   active_len  in   ACTIVE segment length in ticks (0 treated as 1)
//   front_len   in   FRONT porch length in ticks    (0 treated as 1)
//   sync        out  sync pulse, polarity per SYNC_ACTIVE_LOW
//   active      out  1 while in ACTIVE
//   period_end  out  1-clock pulse on the tick that ends FRONT
//   position    out  count within ACTIVE, else 0
//   tick        out  internal advance strobe
module sync_timing_gen #(
  parameter int CW              = 10,
  parameter int SYNC_ACTIVE_LOW = 0,
  parameter int EDGE_DETECT     = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  input  logic [CW-1:0] sync_len,
  input  logic [CW-1:0] back_len,
  input  logic [CW-1:0] active_len,
  input  logic [CW-1:0] front_len,
  output logic          sync,
  output logic          active,
  output logic          period_end,
  output logic [CW-1:0] position,
  output logic          tick
);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_BACK   = 2'd1,
    S_ACTIVE = 2'd2,
    S_FRONT  = 2'd3
  } state_t;

  localparam logic SYNC_POL = (SYNC_ACTIVE_LOW != 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_raw;
  logic [CW-1:0] sync_eff, back_eff, active_eff, front_eff;
  logic [CW-1:0] cur_len, last;
  logic          seg_done;

  // Tick generation
  generate
    if (EDGE_DETECT != 0) begin : g_edge
      logic adv_q, adv_d;
      always_comb adv_d = advance;
      // Clearing adv_q on reset makes a high advance tick on the first clock
      // after reset is released.
      always_ff @(posedge clock) begin
        if (reset) adv_q <= 1'b0;
        else       adv_q <= adv_d;
      end
      assign tick_raw = advance & ~adv_q;
    end else begin : g_level
      assign tick_raw = advance;
    end
  endgenerate

  // Reset wins over a simultaneous tick, and tick reads 0 while in reset.
  assign tick = tick_raw & ~reset;

  // Segment lengths
`ifdef SYNC_GEN_SHADOW_EN
  logic [CW-1:0] sync_len_q, sync_len_d;
  logic [CW-1:0] back_len_q, back_len_d;
  logic [CW-1:0] active_len_q, active_len_d;
  logic [CW-1:0] front_len_q, front_len_d;

  always_comb begin
    sync_len_d   = sync_len_q;
    back_len_d   = back_len_q;
    active_len_d = active_len_q;
    front_len_d  = front_len_q;
    if (reset || period_end) begin
      sync_len_d   = sync_len;
      back_len_d   = back_len;
      active_len_d = active_len;
      front_len_d  = front_len;
    end
  end

  always_ff @(posedge clock) begin
    sync_len_q   <= sync_len_d;
    back_len_q   <= back_len_d;
    active_len_q <= active_len_d;
    front_len_q  <= front_len_d;
  end

  assign sync_eff   = sync_len_q;
  assign back_eff   = back_len_q;
  assign active_eff = active_len_q;
  assign front_eff  = front_len_q;
`else
  assign sync_eff   = sync_len;
  assign back_eff   = back_len;
  assign active_eff = active_len;
  assign front_eff  = front_len;
`endif

  // Segment sequencing
  always_comb begin
    cur_len = sync_eff;
    case (state_q)
      S_SYNC:   cur_len = sync_eff;
      S_BACK:   cur_len = back_eff;
      S_ACTIVE: cur_len = active_eff;
      S_FRONT:  cur_len = front_eff;
      default:  cur_len = sync_eff;
    endcase
    // Zero length behaves as one tick.
    last = (cur_len == '0) ? '0 : cur_len - CW'(1);
    // >= rather than == so a length shrunk below the current count ends the
    // segment on the next tick instead of letting cnt run to wrap-around.
    seg_done = (cnt_q >= last);

    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (seg_done) begin
        cnt_d = '0;
        case (state_q)
          S_SYNC:   state_d = S_BACK;
          S_BACK:   state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_FRONT;
          S_FRONT:  state_d = S_SYNC;
          default:  state_d = S_SYNC;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode, straight from registered state
  assign sync       = (state_q == S_SYNC) ^ SYNC_POL;
  assign active     = (state_q == S_ACTIVE);
  assign position   = active ? cnt_q : '0;
  assign period_end = tick & (state_q == S_FRONT) & seg_done;

endmodule
